// File: rtl/multicycle_sequencer_pkg.sv
// mips_ctrl_pkg: opcode, state, ALU op and trap cause encodings for the multicycle sequencer
package mips_ctrl_pkg;
    localparam int OP_LW   = 0;
    localparam int OP_SW   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_ADDI = 3;
    localparam int OP_BEQ  = 4;
    localparam int OP_B    = 5;

    localparam int ALU_ADD = 0;
    localparam int ALU_CMP = 7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_t;

    function automatic logic is_mem_op(input int op);
        return op == OP_LW || op == OP_SW;
    endfunction
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control bundle between the sequencer and the MIPS datapath
interface multicycle_sequencer_if #(
    parameter int OP_W    = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic               stall;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               retire;
    logic [CNT_W-1:0]   instr_count;
    logic               trap;
    logic [1:0]         trap_cause;

    modport master (
        input  op, zero, mem_ready, stall,
        output i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
               alu_op, reg_write, reg_dst, mem_to_reg, retire, instr_count,
               trap, trap_cause
    );

    modport slave (
        output op, zero, mem_ready, stall,
        input  i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src,
               alu_op, reg_write, reg_dst, mem_to_reg, retire, instr_count,
               trap, trap_cause
    );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request is outstanding and flags the timeout limit
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n || clear || ready) wait_cnt <= '0;
        else if (active) wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = wait_cnt == W'(MEM_TIMEOUT);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the shared datapath strobes, with retire counting and sticky traps.
module multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W        = 5,
    parameter int ALUOP_W     = 3,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic clock,
    input logic reset_n,
    multicycle_sequencer_if.master bus
);
    state_t state, state_d;
    cause_t cause_q, cause_d;
    logic [OP_W-1:0]    op_q;
    logic [CNT_W-1:0]   count;
    logic               trap_q;
    logic               timeout, clear, active;
    logic               i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic               alu_src, reg_write, reg_dst, mem_to_reg, retire;
    logic [ALUOP_W-1:0] alu_op;
    int                 dop, qop;

    assign dop = int'(bus.op);
    assign qop = int'(op_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= FETCH;
            op_q    <= '0;
            count   <= '0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state <= state_d;
            if (state == DECODE) op_q <= bus.op;
            if (retire) count <= count + 1'b1;
            if (state_d == TRAP && state != TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d    = state;
        cause_d    = CAUSE_NONE;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: if (!bus.stall) begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                state_d = dop inside {OP_LW, OP_SW, OP_ADD, OP_ADDI} ? EXEC :
                          dop inside {OP_BEQ, OP_B} ? BRANCH : TRAP;
                cause_d = state_d == TRAP ? CAUSE_ILLEGAL : CAUSE_NONE;
            end
            EXEC: begin
                alu_op  = ALUOP_W'(ALU_ADD);
                alu_src = qop != OP_ADD;
                state_d = is_mem_op(qop) ? MEM : WB;
            end
            MEM: begin
                i_or_d    = 1'b1;
                alu_src   = 1'b1;
                mem_read  = qop == OP_LW;
                mem_write = qop == OP_SW;
                // mem_ready wins over a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    state_d = qop == OP_LW ? WB : FETCH;
                    retire  = qop == OP_SW;
                end else if (timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = qop == OP_LW;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_op   = ALUOP_W'(ALU_CMP);
                pc_src   = 1'b1;
                pc_write = qop == OP_B || bus.zero;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            default: ;
        endcase
    end

    // A stalled FETCH has no request outstanding, so it never ages the timer
    assign active = (state == FETCH && !bus.stall) || state == MEM;
    assign clear  = state_d != state && (state_d == FETCH || state_d == MEM);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .active  (active),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    assign bus.i_or_d      = reset_n & i_or_d;
    assign bus.mem_read    = reset_n & mem_read;
    assign bus.mem_write   = reset_n & mem_write;
    assign bus.ir_write    = reset_n & ir_write;
    assign bus.pc_write    = reset_n & pc_write;
    assign bus.pc_src      = reset_n & pc_src;
    assign bus.alu_src     = reset_n & alu_src;
    assign bus.alu_op      = reset_n ? alu_op : '0;
    assign bus.reg_write   = reset_n & reg_write;
    assign bus.reg_dst     = reset_n & reg_dst;
    assign bus.mem_to_reg  = reset_n & mem_to_reg;
    assign bus.retire      = reset_n & retire;
    assign bus.instr_count = count;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = cause_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed cycle-by-cycle strobe checks, traps, stall and counter wrap
module tb_multicycle_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multicycle_sequencer_if b ();
    multicycle_sequencer_if #(.CNT_W(4)) b4 ();

    multicycle_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(b));
    multicycle_sequencer #(.CNT_W(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(b4));

    assign b4.op        = b.op;
    assign b4.zero      = b.zero;
    assign b4.mem_ready = b.mem_ready;
    assign b4.stall     = b.stall;

    // {i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, alu_op, reg_write, reg_dst, mem_to_reg, retire}
    logic [13:0] strb;
    assign strb = {b.i_or_d, b.mem_read, b.mem_write, b.ir_write, b.pc_write, b.pc_src,
                   b.alu_src, b.alu_op, b.reg_write, b.reg_dst, b.mem_to_reg, b.retire};

    localparam logic [13:0] S_IDLE     = 14'b0;
    localparam logic [13:0] S_F_REQ    = 14'b0_1_0_0_0_0_0_000_0_0_0_0;
    localparam logic [13:0] S_F_RDY    = 14'b0_1_0_1_1_0_0_000_0_0_0_0;
    localparam logic [13:0] S_E_IMM    = 14'b0_0_0_0_0_0_1_000_0_0_0_0;
    localparam logic [13:0] S_M_LW     = 14'b1_1_0_0_0_0_1_000_0_0_0_0;
    localparam logic [13:0] S_M_SW     = 14'b1_0_1_0_0_0_1_000_0_0_0_0;
    localparam logic [13:0] S_M_SW_RET = 14'b1_0_1_0_0_0_1_000_0_0_0_1;
    localparam logic [13:0] S_W_ALU    = 14'b0_0_0_0_0_0_0_000_1_1_0_1;
    localparam logic [13:0] S_W_LW     = 14'b0_0_0_0_0_0_0_000_1_1_1_1;
    localparam logic [13:0] S_BR_NT    = 14'b0_0_0_0_0_1_0_111_0_0_0_1;
    localparam logic [13:0] S_BR_T     = 14'b0_0_0_0_1_1_0_111_0_0_0_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [13:0] exp);
        #1 check(tag, 32'(strb), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    task automatic run_b(input string tag);
        b.op = 5'd5;
        b.mem_ready = 1'b1;
        step({tag, "_f"}, S_F_RDY);
        step({tag, "_d"}, S_IDLE);
        step({tag, "_br"}, S_BR_T);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        b.op = '0;
        b.zero = 1'b0;
        b.mem_ready = 1'b0;
        b.stall = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        b.mem_ready = 1'b1;
        #1 check("rst_strb", 32'(strb), 32'(S_IDLE));
        check("rst_cnt", 32'(b.instr_count), 32'd0);
        check("rst_trap", 32'(b.trap), 32'd0);
        check("rst_cause", 32'(b.trap_cause), 32'd0);
        reset_n = 1'b1;

        b.op = 5'd2;
        step("add_f", S_F_RDY);
        step("add_d", S_IDLE);
        step("add_e", S_IDLE);
        step("add_w", S_W_ALU);
        check("add_cnt", 32'(b.instr_count), 32'd1);

        b.op = 5'd0;
        step("lw_f", S_F_RDY);
        step("lw_d", S_IDLE);
        b.mem_ready = 1'b0;
        step("lw_e", S_E_IMM);
        for (int k = 0; k < 3; k++) step("lw_m_wait", S_M_LW);
        b.mem_ready = 1'b1;
        step("lw_m_rdy", S_M_LW);
        step("lw_w", S_W_LW);
        check("lw_cnt", 32'(b.instr_count), 32'd2);

        b.op = 5'd4;
        step("beq0_f", S_F_RDY);
        step("beq0_d", S_IDLE);
        step("beq0_br", S_BR_NT);
        b.zero = 1'b1;
        step("beq1_f", S_F_RDY);
        step("beq1_d", S_IDLE);
        step("beq1_br", S_BR_T);
        b.zero = 1'b0;
        run_b("b");
        check("br_cnt", 32'(b.instr_count), 32'd5);

        b.op = 5'd9;
        step("ill_f", S_F_RDY);
        step("ill_d", S_IDLE);
        for (int k = 0; k < 20; k++) step("ill_trap_strb", S_IDLE);
        check("ill_trap", 32'(b.trap), 32'd1);
        check("ill_cause", 32'(b.trap_cause), 32'd1);
        check("ill_cnt", 32'(b.instr_count), 32'd5);
        do_reset();
        check("ill_rst_trap", 32'(b.trap), 32'd0);
        check("ill_rst_cause", 32'(b.trap_cause), 32'd0);
        check("ill_rst_cnt", 32'(b.instr_count), 32'd0);

        b.op = 5'd1;
        step("swto_f", S_F_RDY);
        step("swto_d", S_IDLE);
        b.mem_ready = 1'b0;
        step("swto_e", S_E_IMM);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check("swto_pre_trap", 32'(b.trap), 32'd0);
            step("swto_m", S_M_SW);
        end
        #1 check("swto_strb", 32'(strb), 32'(S_IDLE));
        check("swto_trap", 32'(b.trap), 32'd1);
        check("swto_cause", 32'(b.trap_cause), 32'd2);
        check("swto_cnt", 32'(b.instr_count), 32'd0);
        do_reset();

        b.mem_ready = 1'b1;
        step("swok_f", S_F_RDY);
        step("swok_d", S_IDLE);
        b.mem_ready = 1'b0;
        step("swok_e", S_E_IMM);
        for (int k = 0; k < 15; k++) step("swok_m", S_M_SW);
        b.mem_ready = 1'b1;
        step("swok_m_last", S_M_SW_RET);
        check("swok_trap", 32'(b.trap), 32'd0);
        check("swok_cnt", 32'(b.instr_count), 32'd1);

        b.stall = 1'b1;
        b.mem_ready = 1'b0;
        for (int k = 0; k < 20; k++) step("stall_strb", S_IDLE);
        check("stall_trap", 32'(b.trap), 32'd0);
        b.stall = 1'b0;
        b.mem_ready = 1'b1;
        run_b("post_stall");
        check("post_stall_cnt", 32'(b.instr_count), 32'd2);

        for (int k = 0; k < 13; k++) run_b("wrap_fill");
        check("wrap_pre4", 32'(b4.instr_count), 32'hf);
        check("wrap_pre16", 32'(b.instr_count), 32'd15);
        run_b("wrap_last");
        check("wrap_post4", 32'(b4.instr_count), 32'd0);
        check("wrap_post16", 32'(b.instr_count), 32'd16);
        check("wrap_trap", 32'(b.trap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
